// File: rtl/lupdate_gen.sv
// Beacon update transmitter: latches a controller config request and streams a
// 12-word beacon update message (head/body/tail) onto the 134-bit packet bus.
module lupdate_gen #(
  parameter logic [7:0]  LMID     = 8'd12,
  parameter logic [15:0] ETH_TYPE = 16'h1662,
  parameter logic [3:0]  MSG_TYPE = 4'hf,
  parameter int          IPG      = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [47:0]  in_local_mac_id,
  input  logic         in_cfg_req,
  input  logic [47:0]  in_cfg_dst_mac,
  input  logic         in_cfg_direction,
  input  logic [31:0]  in_cfg_token_bucket_para,
  input  logic [47:0]  in_cfg_direct_mac_addr,
  output logic         out_cfg_ack,
  output logic         out_busy,
  input  logic         in_lu_alf,
  output logic [133:0] out_lu_data,
  output logic         out_lu_data_wr,
  output logic         out_lu_data_valid,
  output logic         out_lu_data_valid_wr,
  output logic [7:0]   out_seq
);

  localparam int GAP_W = (IPG > 1) ? $clog2(IPG) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = (IPG > 0) ? GAP_W'(IPG - 1) : '0;
  localparam logic [3:0] LAST_WORD = 4'd11;

  localparam logic [1:0] HDR_HEAD = 2'b01;
  localparam logic [1:0] HDR_BODY = 2'b11;
  localparam logic [1:0] HDR_TAIL = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state;
  logic [3:0]       word_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [7:0]       seq;

  // Request payload captured at acceptance; held constant for the whole packet.
  logic [47:0] lat_dst;
  logic [47:0] lat_src;
  logic        lat_dir;
  logic [31:0] lat_tbp;
  logic [47:0] lat_dmac;

  logic         accept;
  logic [1:0]   word_hdr;
  logic [127:0] word_data;

  assign accept  = (state == IDLE) && in_cfg_req;
  assign out_seq = seq;

  // NOTE: payload latches carry no reset; they are only observed in SEND, which
  // cannot be reached without first loading them on an accepted request.
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_dst  <= in_cfg_dst_mac;
      lat_src  <= in_local_mac_id;
      lat_dir  <= in_cfg_direction;
      lat_tbp  <= in_cfg_token_bucket_para;
      lat_dmac <= in_cfg_direct_mac_addr;
    end
  end

  // Word map of the beacon update message, indexed by word_cnt.
  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // latch is inferred for the word indices that are not listed.
    word_hdr  = HDR_BODY;
    word_data = '0;
    case (word_cnt)
      4'd0: begin
        word_hdr           = HDR_HEAD;
        word_data[127:80]  = lat_dst;
        word_data[79:32]   = lat_src;
        word_data[31:16]   = ETH_TYPE;
        word_data[11:8]    = MSG_TYPE;
        word_data[7:0]     = seq;
      end
      4'd1: word_data[127:120] = LMID;
      4'd5: begin
        word_data[127:80]  = lat_dmac;
        word_data[79]      = lat_dir;
        word_data[63:32]   = lat_tbp;
      end
      LAST_WORD: word_hdr  = HDR_TAIL;
      default: ;
    endcase
  end

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= IDLE;
      word_cnt             <= '0;
      gap_cnt              <= '0;
      seq                  <= '0;
      out_cfg_ack          <= 1'b0;
      out_busy             <= 1'b0;
      out_lu_data          <= '0;
      out_lu_data_wr       <= 1'b0;
      out_lu_data_valid    <= 1'b0;
      out_lu_data_valid_wr <= 1'b0;
    end else begin
      out_cfg_ack          <= 1'b0;
      out_lu_data          <= '0;
      out_lu_data_wr       <= 1'b0;
      out_lu_data_valid    <= 1'b0;
      out_lu_data_valid_wr <= 1'b0;
      case (state)
        IDLE: begin
          if (in_cfg_req) begin
            state       <= SEND;
            word_cnt    <= '0;
            out_cfg_ack <= 1'b1;
            out_busy    <= 1'b1;
          end
        end
        SEND: begin
          // Almost-full only delays the current word; nothing advances.
          if (!in_lu_alf) begin
            out_lu_data    <= {word_hdr, 4'h0, word_data};
            out_lu_data_wr <= 1'b1;
            if (word_cnt == LAST_WORD) begin
              out_lu_data_valid    <= 1'b1;
              out_lu_data_valid_wr <= 1'b1;
              seq                  <= seq + 8'd1;
              word_cnt             <= '0;
              gap_cnt              <= '0;
              if (IPG == 0) begin
                state    <= IDLE;
                out_busy <= 1'b0;
              end else begin
                state    <= GAP;
              end
            end else begin
              word_cnt <= word_cnt + 4'd1;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state    <= IDLE;
            out_busy <= 1'b0;
          end else begin
            gap_cnt  <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          out_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lupdate_gen.sv
// Self-checking bench for lupdate_gen: randomized config requests and almost-full
// backpressure compared against a message-level reference model.
module tb_lupdate_gen;

  localparam int IPG = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [47:0]  in_local_mac_id;
  logic         in_cfg_req;
  logic [47:0]  in_cfg_dst_mac;
  logic         in_cfg_direction;
  logic [31:0]  in_cfg_token_bucket_para;
  logic [47:0]  in_cfg_direct_mac_addr;
  logic         out_cfg_ack;
  logic         out_busy;
  logic         in_lu_alf;
  logic [133:0] out_lu_data;
  logic         out_lu_data_wr;
  logic         out_lu_data_valid;
  logic         out_lu_data_valid_wr;
  logic [7:0]   out_seq;

  always #5 clk = ~clk;

  lupdate_gen #(
    .LMID    (8'd12),
    .ETH_TYPE(16'h1662),
    .MSG_TYPE(4'hf),
    .IPG     (IPG)
  ) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .in_local_mac_id         (in_local_mac_id),
    .in_cfg_req              (in_cfg_req),
    .in_cfg_dst_mac          (in_cfg_dst_mac),
    .in_cfg_direction        (in_cfg_direction),
    .in_cfg_token_bucket_para(in_cfg_token_bucket_para),
    .in_cfg_direct_mac_addr  (in_cfg_direct_mac_addr),
    .out_cfg_ack             (out_cfg_ack),
    .out_busy                (out_busy),
    .in_lu_alf               (in_lu_alf),
    .out_lu_data             (out_lu_data),
    .out_lu_data_wr          (out_lu_data_wr),
    .out_lu_data_valid       (out_lu_data_valid),
    .out_lu_data_valid_wr    (out_lu_data_valid_wr),
    .out_seq                 (out_seq)
  );

  typedef struct packed {
    logic [47:0] dst;
    logic [47:0] src;
    logic        dir;
    logic [31:0] tbp;
    logic [47:0] dmac;
  } cfg_t;

  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  logic [7:0]   m_seq    = 8'd0;
  logic [133:0] rx_words [12];

  task automatic check(input string tag, input logic [133:0] got, input logic [133:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  function automatic cfg_t rand_cfg();
    cfg_t c;
    c.dst  = {$urandom(), $urandom()};
    c.src  = {$urandom(), $urandom()};
    c.dir  = 1'($urandom_range(0, 1));
    c.tbp  = $urandom();
    c.dmac = {$urandom(), $urandom()};
    return c;
  endfunction

  task automatic drive_cfg(input cfg_t c);
    in_cfg_dst_mac           = c.dst;
    in_local_mac_id          = c.src;
    in_cfg_direction         = c.dir;
    in_cfg_token_bucket_para = c.tbp;
    in_cfg_direct_mac_addr   = c.dmac;
  endtask

  // Expected bus word i of a message carrying config c and sequence s.
  function automatic logic [133:0] exp_word(input cfg_t c, input logic [7:0] s, input int i);
    logic [127:0] d;
    logic [1:0]   t;
    d = '0;
    t = (i == 0) ? 2'b01 : ((i == 11) ? 2'b10 : 2'b11);
    case (i)
      0: begin
        d[127:80] = c.dst;
        d[79:32]  = c.src;
        d[31:16]  = 16'h1662;
        d[11:8]   = 4'hf;
        d[7:0]    = s;
      end
      1: d[127:120] = 8'd12;
      5: begin
        d[127:80] = c.dmac;
        d[79]     = c.dir;
        d[63:32]  = c.tbp;
      end
      default: ;
    endcase
    return {t, 4'h0, d};
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ack"},      out_cfg_ack, 1'b0);
    check({tag, "_busy"},     out_busy, 1'b0);
    check({tag, "_wr"},       out_lu_data_wr, 1'b0);
    check({tag, "_data"},     out_lu_data, '0);
    check({tag, "_valid"},    out_lu_data_valid, 1'b0);
    check({tag, "_valid_wr"}, out_lu_data_valid_wr, 1'b0);
    check({tag, "_seq"},      out_seq, 8'd0);
  endtask

  // One message. mode: 0 no stall, 1 random almost-full, 2 three-cycle stall at w3.
  // Returns the cycle of the tail word, or -1 when aborted / no ack.
  task automatic run_msg(input cfg_t c, input int exp_wait, input int mode,
                         input bit keep_req, input bit mutate, input int abort_at,
                         output int tail_cyc);
    int   waited;
    int   idx;
    int   stall_left;
    int   off_cycles;
    bit   alf_now;
    logic [7:0] s;
    tail_cyc   = -1;
    stall_left = 3;
    off_cycles = 0;
    drive_cfg(c);
    in_cfg_req = 1'b1;
    in_lu_alf  = 1'b0;
    waited     = 0;
    while (waited < 30) begin
      tick();
      waited++;
      if (out_cfg_ack) break;
    end
    if (!out_cfg_ack) begin
      check("ack_timeout", 1'b0, 1'b1);
      in_cfg_req = 1'b0;
      return;
    end
    check("ack_latency", 134'(waited), 134'(exp_wait));
    check("ack_busy", out_busy, 1'b1);
    check("ack_wr", out_lu_data_wr, 1'b0);
    s = m_seq;
    if (!keep_req) in_cfg_req = 1'b0;
    if (mutate) drive_cfg(rand_cfg());
    idx = 0;
    for (int n = 0; n < 200 && idx < 12; n++) begin
      alf_now = 1'b0;
      if (mode == 1) alf_now = ($urandom_range(0, 99) < 30);
      if (mode == 2 && idx == 3 && stall_left > 0) begin
        alf_now = 1'b1;
        stall_left--;
      end
      in_lu_alf = alf_now;
      tick();
      if (mutate) drive_cfg(rand_cfg());
      check("wr_vs_alf", out_lu_data_wr, !alf_now);
      check("no_reack", out_cfg_ack, 1'b0);
      check("busy_send", out_busy, 1'b1);
      if (out_lu_data_wr) begin
        rx_words[idx] = out_lu_data;
        check($sformatf("word%0d", idx), out_lu_data, exp_word(c, s, idx));
        check("valid_wr", out_lu_data_valid_wr, idx == 11);
        check("valid", out_lu_data_valid, idx == 11);
        if (idx == abort_at) begin
          in_lu_alf  = 1'b0;
          in_cfg_req = 1'b0;
          rst_n      = 1'b0;
          #1;
          check_idle_outputs("abort");
          m_seq = 8'd0;
          return;
        end
        if (idx == 11) tail_cyc = cyc;
        idx++;
      end else begin
        off_cycles++;
        check("stall_data", out_lu_data, '0);
        check("stall_valid_wr", out_lu_data_valid_wr, 1'b0);
      end
    end
    in_lu_alf = 1'b0;
    if (idx != 12) begin
      check("packet_timeout", 134'(idx), 134'(12));
      return;
    end
    if (mode == 2) check("stall_cycles", 134'(off_cycles), 134'(3));
    m_seq = m_seq + 8'd1;
    check("out_seq", out_seq, m_seq);
  endtask

  // Called at the tail cycle with request low: busy holds through the gap.
  task automatic check_gap();
    for (int i = 1; i <= IPG; i++) begin
      tick();
      check("gap_busy", out_busy, i < IPG);
      check("gap_wr", out_lu_data_wr, 1'b0);
      check("gap_ack", out_cfg_ack, 1'b0);
    end
  endtask

  initial begin
    cfg_t c;
    int   t_prev;
    int   t_cur;
    logic        rx_dir;
    logic [31:0] rx_tbp;
    logic [47:0] rx_dmac;
    bit          rx_hit;

    rst_n      = 1'b0;
    in_cfg_req = 1'b0;
    in_lu_alf  = 1'b0;
    drive_cfg('0);
    tick();
    tick();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Directed first message, no backpressure.
    c.dst  = 48'h0A0B0C0D0E0F;
    c.src  = 48'h020000000001;
    c.dir  = 1'b1;
    c.tbp  = 32'h12345678;
    c.dmac = 48'h112233445566;
    run_msg(c, 1, 0, 1'b0, 1'b0, -1, t_cur);
    check("t1_w5_dir", rx_words[5][79], 1'b1);
    check("t1_w5_tbp", rx_words[5][63:32], 32'h12345678);
    check_gap();

    // Three-cycle almost-full stall starting at w3.
    run_msg(rand_cfg(), 1, 2, 1'b0, 1'b0, -1, t_cur);
    check_gap();

    // Random backpressure.
    for (int k = 0; k < 6; k++) begin
      run_msg(rand_cfg(), 1, 1, 1'b0, 1'b0, -1, t_cur);
      check_gap();
    end

    // Inputs change during the packet; request stays high so no early re-ack.
    run_msg(rand_cfg(), 1, 1, 1'b1, 1'b1, -1, t_cur);
    in_cfg_req = 1'b0;
    check_gap();

    // Held request back-to-back through a full sequence wrap.
    run_msg(rand_cfg(), 1, 0, 1'b1, 1'b0, -1, t_prev);
    for (int k = 0; k < 256; k++) begin
      run_msg(rand_cfg(), IPG + 1, 0, 1'b1, 1'b0, -1, t_cur);
      if (k < 4 || k > 250) check("tail_spacing", 134'(t_cur - t_prev), 134'(12 + IPG + 1));
      t_prev = t_cur;
    end
    in_cfg_req = 1'b0;
    check_gap();

    // Async reset in the middle of a packet.
    run_msg(rand_cfg(), 1, 0, 1'b0, 1'b0, 6, t_cur);
    tick();
    check_idle_outputs("abort_next");
    rst_n = 1'b1;
    tick();
    run_msg(rand_cfg(), 1, 1, 1'b0, 1'b0, -1, t_cur);
    check("post_abort_seq", rx_words[0][7:0], 8'd0);
    check_gap();

    // Loopback into a receiver whose local MAC matches the destination.
    c = rand_cfg();
    run_msg(c, 1, 1, 1'b0, 1'b0, -1, t_cur);
    rx_hit  = (rx_words[0][127:80] == c.dst) && (rx_words[0][11:8] == 4'hf);
    rx_dir  = rx_hit ? rx_words[5][79] : 1'b0;
    rx_tbp  = rx_hit ? rx_words[5][63:32] : 32'h0;
    rx_dmac = rx_hit ? rx_words[5][127:80] : 48'h0;
    check("rx_match", rx_hit, 1'b1);
    check("rx_direction", rx_dir, c.dir);
    check("rx_tbp", rx_tbp, c.tbp);
    check("rx_dmac", rx_dmac, c.dmac);
    check_gap();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
